cpu_ctrl_mc: RTL and testbench

CPU_CTRL_MC -- requirements
Module: cpu_ctrl_mc

---
 rtl/cpu_ctrl_mc.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cpu_ctrl_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_mc.sv
// cpu_ctrl_mc: multi-cycle MIPS-subset control unit.
// The state register is clocked. Every output is decoded combinationally from state and inputs.
//
// Parameters:
//   MEM_TIMEOUT : maximum number of cycles spent waiting for mem_ready in one memory state
//   TRAP_VEC    : PC value loaded on a trap; the datapath applies it when PCSource=3
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   Inst                 : IR contents (opcode [31:26], funct [5:0])
//   Zero                 : ALU zero flag
//   mem_ready            : memory completes the current access this cycle
//   int_req              : level interrupt request (used only with CTRL_INT_EN)
//   mem_req/MemWrite/IorD/IRWrite, PCWrite, PCSource : memory and PC controls
//   RegWrite/RegDst/Jal/ALUSrc_A/EXTLog, ALUSrc_B, DatatoReg, ALUControl : datapath controls
//   state                : current state (debug)
//   inst_done, trap      : one-cycle retire and trap-entry pulses
// Configuration macro: CTRL_INT_EN enables taking interrupts at instruction retire.
module cpu_ctrl_mc #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Inst,
  input  logic        Zero,
  input  logic        mem_ready,
  input  logic        int_req,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSource,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        Jal,
  output logic        ALUSrc_A,
  output logic        EXTLog,
  output logic [1:0]  ALUSrc_B,
  output logic [1:0]  DatatoReg,
  output logic [3:0]  ALUControl,
  output logic [3:0]  state,
  output logic        inst_done,
  output logic        trap
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MA   = 4'd3,
    S_MRD  = 4'd4,
    S_MWR  = 4'd5,
    S_WB   = 4'd6,
    S_BR   = 4'd7,
    S_JMP  = 4'd8,
    S_TRAP = 4'd9
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e, OP_LUI  = 6'h0f, OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3, ALU_NOR = 4'd4, ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6, ALU_SLT = 4'd7, ALU_SLL = 4'd8;

  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_TRAP = 2'd3;
  localparam logic [1:0] B_RT = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2, B_IMMSH = 2'd3;
  localparam logic [1:0] D_ALU = 2'd0, D_MEM = 2'd1, D_LUI = 2'd2, D_PC = 2'd3;

  state_t           state_q, state_nxt, retire_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [5:0]       op, fn;
  logic             is_r, is_nop, is_alu, is_shift, is_logi, is_jr;
  logic [3:0]       alu_op;
  logic             timeout, fetch_done, int_hit;

  assign op         = Inst[31:26];
  assign fn         = Inst[5:0];
  assign is_r       = (op == OP_R);
  assign is_nop     = (Inst == 32'd0);
  assign timeout    = !mem_ready && (wait_cnt == CNT_LAST);
  // Qualify with rst_n so a mem_ready seen during reset cannot load IR or PC.
  assign fetch_done = mem_ready && rst_n;
  assign state      = 4'(state_q);

`ifdef CTRL_INT_EN
  assign int_hit = int_req;
  logic unused_cfg;
  assign unused_cfg = ^TRAP_VEC;
`else
  assign int_hit = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{TRAP_VEC, int_req};
`endif

  // Retiring instructions go back to fetch unless an interrupt is pending.
  assign retire_nxt = int_hit ? S_TRAP : S_IF;

  // Instruction decode: the ALU class, the ALU op and the operand-select modifiers.
  always_comb begin
    is_alu   = 1'b0;
    is_shift = 1'b0;
    is_logi  = 1'b0;
    is_jr    = 1'b0;
    alu_op   = ALU_ADD;
    if (is_r) begin
      case (fn)
        FN_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD; end
        FN_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB; end
        FN_AND: begin is_alu = 1'b1; alu_op = ALU_AND; end
        FN_OR:  begin is_alu = 1'b1; alu_op = ALU_OR;  end
        FN_XOR: begin is_alu = 1'b1; alu_op = ALU_XOR; end
        FN_NOR: begin is_alu = 1'b1; alu_op = ALU_NOR; end
        FN_SLT: begin is_alu = 1'b1; alu_op = ALU_SLT; end
        FN_SRL: begin is_alu = 1'b1; is_shift = 1'b1; alu_op = ALU_SRL; end
        FN_SLL: begin is_alu = 1'b1; is_shift = 1'b1; alu_op = ALU_SLL; end
        FN_JR:  is_jr = 1'b1;
        default: ;
      endcase
    end else begin
      case (op)
        OP_ADDI: begin is_alu = 1'b1; alu_op = ALU_ADD; end
        OP_SLTI: begin is_alu = 1'b1; alu_op = ALU_SLT; end
        OP_ANDI: begin is_alu = 1'b1; is_logi = 1'b1; alu_op = ALU_AND; end
        OP_ORI:  begin is_alu = 1'b1; is_logi = 1'b1; alu_op = ALU_OR;  end
        OP_XORI: begin is_alu = 1'b1; is_logi = 1'b1; alu_op = ALU_XOR; end
        OP_LUI:  begin is_alu = 1'b1; alu_op = ALU_ADD; end
        default: ;
      endcase
    end
  end

  // State register and memory wait counter; the counter clears whenever the state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IF;
      wait_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_nxt != state_q) wait_cnt <= '0;
      else                      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state_q;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSource   = PC_ALU;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    Jal        = 1'b0;
    ALUSrc_A   = 1'b0;
    EXTLog     = 1'b0;
    ALUSrc_B   = B_RT;
    DatatoReg  = D_ALU;
    ALUControl = ALU_AND;
    inst_done  = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        if (fetch_done) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          PCSource   = PC_ALU;
          ALUSrc_B   = B_FOUR;
          ALUControl = ALU_ADD;
          state_nxt  = S_ID;
        end else if (timeout && rst_n) begin
          state_nxt = S_TRAP;
        end
      end
      S_ID: begin
        ALUSrc_B   = B_IMMSH;
        ALUControl = ALU_ADD;
        if (is_nop) begin
          inst_done = 1'b1;
          state_nxt = retire_nxt;
        end else if (is_alu)                      state_nxt = S_EX;
        else if (op == OP_LW || op == OP_SW)      state_nxt = S_MA;
        else if (op == OP_BEQ || op == OP_BNE)    state_nxt = S_BR;
        else if (op == OP_J || op == OP_JAL || is_jr) state_nxt = S_JMP;
        else                                      state_nxt = S_TRAP;
      end
      S_EX: begin
        ALUSrc_B   = is_r ? B_RT : B_IMM;
        ALUSrc_A   = is_shift;
        EXTLog     = is_logi;
        ALUControl = alu_op;
        state_nxt  = S_WB;
      end
      S_MA: begin
        ALUSrc_B   = B_IMM;
        ALUControl = ALU_ADD;
        state_nxt  = (op == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)    state_nxt = S_WB;
        else if (timeout) state_nxt = S_TRAP;
      end
      S_MWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          inst_done = 1'b1;
          state_nxt = retire_nxt;
        end else if (timeout) begin
          state_nxt = S_TRAP;
        end
      end
      S_WB: begin
        RegWrite  = 1'b1;
        RegDst    = is_r;
        if (op == OP_LUI)     DatatoReg = D_LUI;
        else if (op == OP_LW) DatatoReg = D_MEM;
        inst_done = 1'b1;
        state_nxt = retire_nxt;
      end
      S_BR: begin
        ALUSrc_B   = B_RT;
        ALUControl = ALU_SUB;
        PCWrite    = (op == OP_BNE) ? !Zero : Zero;
        PCSource   = PC_ALUOUT;
        inst_done  = 1'b1;
        state_nxt  = retire_nxt;
      end
      S_JMP: begin
        PCWrite = 1'b1;
        if (is_jr) begin
          // jr has rt=$0, so rs + rt passes rs through the ALU.
          PCSource   = PC_ALU;
          ALUSrc_B   = B_RT;
          ALUControl = ALU_ADD;
        end else begin
          PCSource = PC_JUMP;
        end
        if (op == OP_JAL) begin
          RegWrite  = 1'b1;
          Jal       = 1'b1;
          DatatoReg = D_PC;
        end
        inst_done = 1'b1;
        state_nxt = retire_nxt;
      end
      S_TRAP: begin
        PCWrite   = 1'b1;
        PCSource  = PC_TRAP;
        trap      = 1'b1;
        state_nxt = S_IF;
      end
      default: state_nxt = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_mc.sv
// Directed testbench for cpu_ctrl_mc with hand-computed expected values.
module tb_cpu_ctrl_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Inst;
  logic        Zero, mem_ready, int_req;
  logic        mem_req, MemWrite, IorD, IRWrite, PCWrite;
  logic [1:0]  PCSource;
  logic        RegWrite, RegDst, Jal, ALUSrc_A, EXTLog;
  logic [1:0]  ALUSrc_B, DatatoReg;
  logic [3:0]  ALUControl, state;
  logic        inst_done, trap;
  logic [21:0] ctl;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_SLL  = 32'h0002_1900;
  localparam logic [31:0] I_ANDI = 32'h3022_00FF;
  localparam logic [31:0] I_LUI  = 32'h3C02_1234;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0008;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_BNE  = 32'h1422_0003;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  cpu_ctrl_mc dut (
    .clk(clk), .rst_n(rst_n), .Inst(Inst), .Zero(Zero), .mem_ready(mem_ready),
    .int_req(int_req), .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .RegWrite(RegWrite),
    .RegDst(RegDst), .Jal(Jal), .ALUSrc_A(ALUSrc_A), .EXTLog(EXTLog),
    .ALUSrc_B(ALUSrc_B), .DatatoReg(DatatoReg), .ALUControl(ALUControl),
    .state(state), .inst_done(inst_done), .trap(trap)
  );

  always #5 clk = ~clk;

  assign ctl = {mem_req, MemWrite, IorD, IRWrite, PCWrite, PCSource, RegWrite, RegDst,
                Jal, ALUSrc_A, EXTLog, ALUSrc_B, DatatoReg, ALUControl, inst_done, trap};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single-cycle fetch with memory ready; ends in ID.
  task automatic fetch(input logic [31:0] ins, input string tag);
    Inst = ins;
    mem_ready = 1'b1;
    #1;
    chk({tag, " IF state"}, 32'(state), 32'd0);
    chk({tag, " IF IRWrite"}, 32'(IRWrite), 32'd1);
    tick;
    chk({tag, " ID state"}, 32'(state), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; Inst = 32'd0; Zero = 1'b0; mem_ready = 1'b1; int_req = 1'b0;
    #12;
    chk("reset state", 32'(state), 32'd0);
    chk("reset outputs", 32'(ctl), 32'h0020_0000);

    // add $3,$1,$2 with an interrupt request held throughout
    rst_n = 1'b1; int_req = 1'b1;
    fetch(I_ADD, "add");
    chk("add IF->ID pc ALUSrc_B", 32'(ALUSrc_B), 32'd3);
    chk("add ID ALUControl", 32'(ALUControl), 32'd2);
    tick;
    chk("add EX state", 32'(state), 32'd2);
    chk("add EX ALUSrc_B", 32'(ALUSrc_B), 32'd0);
    chk("add EX ALUControl", 32'(ALUControl), 32'd2);
    tick;
    chk("add WB state", 32'(state), 32'd6);
    chk("add WB RegWrite", 32'(RegWrite), 32'd1);
    chk("add WB RegDst", 32'(RegDst), 32'd1);
    chk("add WB inst_done", 32'(inst_done), 32'd1);
    tick;
`ifdef CTRL_INT_EN
    chk("int after WB state", 32'(state), 32'd9);
    chk("int trap pulse", 32'(trap), 32'd1);
    chk("int no inst_done", 32'(inst_done), 32'd0);
    int_req = 1'b0;
    tick;
`endif
    chk("after add state", 32'(state), 32'd0);
    int_req = 1'b0;

    // IF holds while memory is not ready
    Inst = I_SLL; mem_ready = 1'b0; #1;
    chk("IF wait IRWrite", 32'(IRWrite), 32'd0);
    chk("IF wait mem_req", 32'(mem_req), 32'd1);
    tick;
    chk("IF wait state", 32'(state), 32'd0);
    fetch(I_SLL, "sll");
    tick;
    chk("sll EX ALUSrc_A", 32'(ALUSrc_A), 32'd1);
    chk("sll EX ALUControl", 32'(ALUControl), 32'd8);
    tick; tick;

    // andi
    fetch(I_ANDI, "andi");
    tick;
    chk("andi EX EXTLog", 32'(EXTLog), 32'd1);
    chk("andi EX ALUSrc_B", 32'(ALUSrc_B), 32'd2);
    chk("andi EX ALUControl", 32'(ALUControl), 32'd0);
    tick;
    chk("andi WB RegDst", 32'(RegDst), 32'd0);
    tick;

    // lui
    fetch(I_LUI, "lui");
    tick; tick;
    chk("lui WB DatatoReg", 32'(DatatoReg), 32'd2);
    tick;

    // lw with memory delayed three cycles in MRD
    fetch(I_LW, "lw");
    tick;
    chk("lw MA state", 32'(state), 32'd3);
    chk("lw MA ALUSrc_B", 32'(ALUSrc_B), 32'd2);
    mem_ready = 1'b0;
    tick;
    chk("lw MRD IorD", 32'(IorD), 32'd1);
    chk("lw MRD MemWrite", 32'(MemWrite), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lw MRD wait state", 32'(state), 32'd4);
      tick;
    end
    chk("lw MRD 4th state", 32'(state), 32'd4);
    mem_ready = 1'b1;
    tick;
    chk("lw WB state", 32'(state), 32'd6);
    chk("lw WB DatatoReg", 32'(DatatoReg), 32'd1);
    chk("lw WB RegWrite", 32'(RegWrite), 32'd1);
    tick;

    // lw with mem_ready arriving on the timeout cycle: ready wins
    fetch(I_LW, "lw edge");
    tick;
    mem_ready = 1'b0;
    tick;
    for (int i = 0; i < 14; i++) tick;
    chk("lw edge still MRD", 32'(state), 32'd4);
    mem_ready = 1'b1;
    tick;
    chk("lw edge WB state", 32'(state), 32'd6);
    tick;

    // sw with memory never ready: timeout into TRAP
    fetch(I_SW, "sw");
    tick;
    mem_ready = 1'b0;
    tick;
    chk("sw MWR MemWrite", 32'(MemWrite), 32'd1);
    for (int i = 0; i < 15; i++) begin
      chk("sw MWR wait state", 32'(state), 32'd5);
      tick;
    end
    chk("sw TRAP state", 32'(state), 32'd9);
    chk("sw TRAP trap", 32'(trap), 32'd1);
    chk("sw TRAP PCSource", 32'(PCSource), 32'd3);
    chk("sw TRAP PCWrite", 32'(PCWrite), 32'd1);
    chk("sw TRAP inst_done", 32'(inst_done), 32'd0);
    mem_ready = 1'b1;
    tick;
    chk("after trap state", 32'(state), 32'd0);

    // beq not taken, then taken; bne taken
    fetch(I_BEQ, "beq0");
    Zero = 1'b0;
    tick;
    chk("beq0 BR state", 32'(state), 32'd7);
    chk("beq0 PCWrite", 32'(PCWrite), 32'd0);
    chk("beq0 PCSource", 32'(PCSource), 32'd1);
    chk("beq0 ALUControl", 32'(ALUControl), 32'd6);
    chk("beq0 inst_done", 32'(inst_done), 32'd1);
    tick;
    fetch(I_BEQ, "beq1");
    tick;
    Zero = 1'b1; #1;
    chk("beq1 PCWrite", 32'(PCWrite), 32'd1);
    tick;
    fetch(I_BNE, "bne");
    tick;
    Zero = 1'b0; #1;
    chk("bne PCWrite", 32'(PCWrite), 32'd1);
    tick;

    // jal and jr
    fetch(I_JAL, "jal");
    tick;
    chk("jal JMP state", 32'(state), 32'd8);
    chk("jal PCSource", 32'(PCSource), 32'd2);
    chk("jal Jal", 32'(Jal), 32'd1);
    chk("jal DatatoReg", 32'(DatatoReg), 32'd3);
    chk("jal RegWrite", 32'(RegWrite), 32'd1);
    tick;
    fetch(I_JR, "jr");
    tick;
    chk("jr PCWrite", 32'(PCWrite), 32'd1);
    chk("jr PCSource", 32'(PCSource), 32'd0);
    chk("jr RegWrite", 32'(RegWrite), 32'd0);
    tick;

    // NOP retires from ID
    fetch(32'd0, "nop");
    chk("nop ID inst_done", 32'(inst_done), 32'd1);
    tick;
    chk("nop next state", 32'(state), 32'd0);

    // illegal opcode traps from ID
    fetch(I_BAD, "bad");
    chk("bad ID inst_done", 32'(inst_done), 32'd0);
    tick;
    chk("bad TRAP state", 32'(state), 32'd9);
    chk("bad TRAP trap", 32'(trap), 32'd1);
    tick;

    // asynchronous reset in the middle of MRD
    fetch(I_LW, "lw rst");
    tick;
    mem_ready = 1'b0;
    tick; tick;
    chk("lw rst in MRD", 32'(state), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset outputs", 32'(ctl), 32'h0020_0000);
    #1;
    rst_n = 1'b1;
    Inst = I_ADD; mem_ready = 1'b1;
    tick;
    chk("post reset fetch", 32'(state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
